// File: rtl/retire_stage.sv
// retire_stage: in-order commit from the ROB head window.
// Frees pregs, updates the arch map, commits stores, drains on halt.
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif
`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

package retire_pkg;
  typedef struct packed {
    logic                      complete;
    logic                      halt;
    logic                      is_store;
    logic [4:0]                dest_arch;
    logic [`PHYS_REG_BITS-1:0] t_new;
    logic [`PHYS_REG_BITS-1:0] t_old;
    logic [31:0]               pc;
  } ROB_EXIT_PACKET;
endpackage

module retire_stage
  import retire_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 1024,
  parameter int CNT_BITS        = 64
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  ROB_EXIT_PACKET [`N-1:0]                  rob_outputs,
  input  logic [`NUM_SCALAR_BITS-1:0]              rob_outputs_valid,
  output logic [`NUM_SCALAR_BITS-1:0]              num_retiring,
  input  logic                                     store_commit_ready,
  output logic                                     store_commit_valid,
  input  logic                                     store_buffer_empty,
  output logic [`N-1:0]                            free_valid,
  output logic [`N-1:0][`PHYS_REG_BITS-1:0]        free_preg,
  output logic [`N-1:0]                            arch_map_we,
  output logic [`N-1:0][4:0]                       arch_map_idx,
  output logic [`N-1:0][`PHYS_REG_BITS-1:0]        arch_map_preg,
  output logic                                     halted,
  output logic [CNT_BITS-1:0]                      retired_count,
  output logic                                     deadlock
);

  localparam int WD_BITS = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_BITS-1:0] WD_MAX = WD_BITS'(WATCHDOG_CYCLES);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t               state_q, state_d;
  logic [WD_BITS-1:0]   wd_q, wd_d;
  logic                 dead_d;
  logic                 run;
  logic [`N-1:0]        retire;
  logic [`N-1:0]        shadowed;
  logic                 store_hit;
  logic                 halt_hit;
  logic                 go;
  logic                 unused_pc;

  assign run = (state_q == RUN) && !reset;

  // Oldest-first scan; first failing slot blocks everything younger.
  always_comb begin
    retire       = '0;
    num_retiring = '0;
    store_hit    = 1'b0;
    halt_hit     = 1'b0;
    go           = run;
    for (int i = 0; i < `N; i++) begin
      if (go && i < int'(rob_outputs_valid)
          && rob_outputs[i].complete && !halt_hit
          && !(rob_outputs[i].is_store
               && (store_hit || !store_commit_ready))) begin
        retire[i]    = 1'b1;
        num_retiring = num_retiring + 1'b1;
        store_hit    = store_hit | rob_outputs[i].is_store;
        halt_hit     = halt_hit | rob_outputs[i].halt;
      end else begin
        go = 1'b0;
      end
    end
  end

  assign store_commit_valid = store_hit;

  // A younger retiring write to the same arch reg owns the mapping.
  always_comb begin
    shadowed = '0;
    for (int i = 0; i < `N; i++) begin
      for (int j = 0; j < `N; j++) begin
        if (j > i && retire[j]
            && rob_outputs[j].dest_arch == rob_outputs[i].dest_arch)
          shadowed[i] = 1'b1;
      end
    end
  end

  always_comb begin
    free_valid    = '0;
    free_preg     = '0;
    arch_map_we   = '0;
    arch_map_idx  = '0;
    arch_map_preg = '0;
    for (int i = 0; i < `N; i++) begin
      if (retire[i] && rob_outputs[i].dest_arch != 5'd0) begin
        free_valid[i] = 1'b1;
        free_preg[i]  = rob_outputs[i].t_old;
        if (!shadowed[i]) begin
          arch_map_we[i]   = 1'b1;
          arch_map_idx[i]  = rob_outputs[i].dest_arch;
          arch_map_preg[i] = rob_outputs[i].t_new;
        end
      end
    end
  end

  always_comb begin
    unused_pc = 1'b0;
    for (int i = 0; i < `N; i++)
      unused_pc = unused_pc ^ (^rob_outputs[i].pc);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_hit) state_d = DRAIN;
      DRAIN:   if (store_buffer_empty) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Watchdog only advances while running; drain/halt freeze it.
  always_comb begin
    wd_d = wd_q;
    if (state_q == RUN) begin
      if (rob_outputs_valid == '0 || num_retiring != '0)
        wd_d = '0;
      else if (wd_q != WD_MAX)
        wd_d = wd_q + 1'b1;
    end
    dead_d = deadlock | ((state_q == RUN) && (wd_d == WD_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      wd_q          <= '0;
      deadlock      <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      deadlock      <= dead_d;
      retired_count <= retired_count + CNT_BITS'(num_retiring);
    end
  end

  assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed test-plan cases plus random windows
// checked against an arithmetic reference model.
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif
`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

module tb_retire_stage;
  import retire_pkg::*;

  localparam int WD = 8;
  localparam int PB = `PHYS_REG_BITS;

  logic                            clock;
  logic                            reset;
  ROB_EXIT_PACKET [`N-1:0]         rob_outputs;
  logic [`NUM_SCALAR_BITS-1:0]     rob_outputs_valid;
  logic [`NUM_SCALAR_BITS-1:0]     num_retiring;
  logic                            store_commit_ready;
  logic                            store_commit_valid;
  logic                            store_buffer_empty;
  logic [`N-1:0]                   free_valid;
  logic [`N-1:0][PB-1:0]           free_preg;
  logic [`N-1:0]                   arch_map_we;
  logic [`N-1:0][4:0]              arch_map_idx;
  logic [`N-1:0][PB-1:0]           arch_map_preg;
  logic                            halted;
  logic [63:0]                     retired_count;
  logic                            deadlock;

  retire_stage #(.WATCHDOG_CYCLES(WD), .CNT_BITS(64)) dut (
    .clock              (clock),
    .reset              (reset),
    .rob_outputs        (rob_outputs),
    .rob_outputs_valid  (rob_outputs_valid),
    .num_retiring       (num_retiring),
    .store_commit_ready (store_commit_ready),
    .store_commit_valid (store_commit_valid),
    .store_buffer_empty (store_buffer_empty),
    .free_valid         (free_valid),
    .free_preg          (free_preg),
    .arch_map_we        (arch_map_we),
    .arch_map_idx       (arch_map_idx),
    .arch_map_preg      (arch_map_preg),
    .halted             (halted),
    .retired_count      (retired_count),
    .deadlock           (deadlock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference state: 0 run, 1 drain, 2 halted
  int                    m_state = 0;
  longint unsigned       m_count = 0;
  int                    m_wd = 0;
  bit                    m_dead = 0;

  int                    e_n;
  bit                    e_store, e_halt;
  logic [`N-1:0]         e_fv, e_we;
  logic [`N-1:0][PB-1:0] e_fp, e_pr;
  logic [`N-1:0][4:0]    e_idx;

  task automatic model_comb();
    bit [31:0] seen;
    int d;
    e_n = 0; e_store = 0; e_halt = 0;
    e_fv = '0; e_we = '0; e_fp = '0; e_pr = '0; e_idx = '0;
    if (!reset && m_state == 0) begin
      for (int i = 0; i < int'(rob_outputs_valid); i++) begin
        if (!rob_outputs[i].complete || e_halt) break;
        if (rob_outputs[i].is_store && (e_store || !store_commit_ready))
          break;
        e_n++;
        if (rob_outputs[i].is_store) e_store = 1;
        if (rob_outputs[i].halt) e_halt = 1;
      end
      seen = '0;
      for (int i = e_n - 1; i >= 0; i--) begin
        d = int'(rob_outputs[i].dest_arch);
        if (d != 0) begin
          e_fv[i] = 1'b1;
          e_fp[i] = rob_outputs[i].t_old;
          if (!seen[d]) begin
            seen[d]  = 1'b1;
            e_we[i]  = 1'b1;
            e_idx[i] = rob_outputs[i].dest_arch;
            e_pr[i]  = rob_outputs[i].t_new;
          end
        end
      end
    end
  endtask

  task automatic model_next();
    if (reset) begin
      m_state = 0; m_count = 0; m_wd = 0; m_dead = 0;
    end else begin
      m_count += longint'(e_n);
      if (m_state == 0) begin
        if (rob_outputs_valid == 0 || e_n > 0) m_wd = 0;
        else if (m_wd < WD) m_wd++;
        if (m_wd == WD) m_dead = 1;
        if (e_halt) m_state = 1;
      end else if (m_state == 1) begin
        if (store_buffer_empty) m_state = 2;
      end
    end
  endtask

  // sample at negedge, after inputs settled
  task automatic eval();
    logic [`N-1:0][PB-1:0] g_fp, g_pr;
    logic [`N-1:0][4:0]    g_idx;
    @(negedge clock);
    model_comb();
    g_fp = free_preg; g_pr = arch_map_preg; g_idx = arch_map_idx;
    for (int i = 0; i < `N; i++) begin
      if (i < e_n && !e_fv[i]) g_fp[i] = '0;
      if (i < e_n && !e_we[i]) begin
        g_pr[i] = '0; g_idx[i] = '0;
      end
    end
    chk("num_retiring", num_retiring, e_n);
    chk("store_commit_valid", store_commit_valid, e_store);
    chk("free_valid", free_valid, e_fv);
    chk("free_preg", g_fp, e_fp);
    chk("arch_map_we", arch_map_we, e_we);
    chk("arch_map_idx", g_idx, e_idx);
    chk("arch_map_preg", g_pr, e_pr);
    chk("halted", halted, m_state == 2);
    chk("retired_count", retired_count, m_count);
    chk("deadlock", deadlock, m_dead);
  endtask

  task automatic advance();
    model_next();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    eval();
    advance();
  endtask

  task automatic clear_window();
    rob_outputs = '0;
    rob_outputs_valid = '0;
  endtask

  task automatic slot(input int i, input bit c, input bit h, input bit s,
                      input int d, input int t_old, input int t_new);
    rob_outputs[i].complete  = c;
    rob_outputs[i].halt      = h;
    rob_outputs[i].is_store  = s;
    rob_outputs[i].dest_arch = 5'(d);
    rob_outputs[i].t_old     = PB'(t_old);
    rob_outputs[i].t_new     = PB'(t_new);
    rob_outputs[i].pc        = 32'(32'h1000 + 4 * i);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_window();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  int halted_run;

  initial begin
    reset = 1'b1;
    store_commit_ready = 1'b1;
    store_buffer_empty = 1'b0;
    clear_window();
    do_reset();

    // all three complete, distinct dests
    rob_outputs_valid = 3;
    slot(0, 1, 0, 0, 1, 11, 21);
    slot(1, 1, 0, 0, 2, 12, 22);
    slot(2, 1, 0, 0, 3, 13, 23);
    eval();
    chk("tp1_num", num_retiring, 3);
    chk("tp1_we", arch_map_we, 3'b111);
    advance();

    // middle slot incomplete
    slot(1, 0, 0, 0, 2, 12, 22);
    eval();
    chk("tp1_count", retired_count, 3);
    chk("tp2_fv", free_valid, 3'b001);
    advance();

    // two stores: one commit at most, none without ready
    slot(0, 1, 0, 1, 0, 0, 0);
    slot(1, 1, 0, 1, 0, 0, 0);
    slot(2, 1, 0, 0, 4, 14, 24);
    eval();
    chk("tp3_num", num_retiring, 1);
    advance();
    store_commit_ready = 1'b0;
    eval();
    chk("tp3_nr_num", num_retiring, 0);
    chk("tp3_nr_scv", store_commit_valid, 0);
    advance();
    store_commit_ready = 1'b1;

    // same dest in slots 0 and 2
    slot(0, 1, 0, 0, 5, 10, 20);
    slot(1, 1, 0, 0, 6, 11, 21);
    slot(2, 1, 0, 0, 5, 12, 22);
    eval();
    chk("tp4_we", arch_map_we, 3'b110);
    chk("tp4_fp0", free_preg[0], 10);
    chk("tp4_fp2", free_preg[2], 12);
    chk("tp4_pr2", arch_map_preg[2], 22);
    advance();

    // halt in slot 1, slow store buffer drain
    slot(0, 1, 0, 0, 7, 15, 25);
    slot(1, 1, 1, 0, 0, 0, 0);
    slot(2, 1, 0, 0, 8, 16, 26);
    store_buffer_empty = 1'b0;
    eval();
    chk("tp5_num", num_retiring, 2);
    advance();
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("tp5_drain_num", num_retiring, 0);
      chk("tp5_drain_halted", halted, 0);
      advance();
    end
    store_buffer_empty = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("tp5_halted", halted, 1);
      advance();
    end

    // watchdog: one entry that never completes
    do_reset();
    clear_window();
    rob_outputs_valid = 1;
    slot(0, 0, 0, 0, 9, 17, 27);
    for (int k = 0; k <= 8; k++) begin
      eval();
      if (k == 7) chk("wd_edge7", deadlock, 0);
      if (k == 8) chk("wd_edge8", deadlock, 1);
      advance();
    end
    slot(0, 1, 0, 0, 9, 17, 27);
    cycle();
    eval();
    chk("wd_sticky", deadlock, 1);
    advance();
    do_reset();
    eval();
    chk("wd_cleared", deadlock, 0);
    advance();

    // random windows
    halted_run = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0) || (halted_run > 3);
      rob_outputs_valid = `NUM_SCALAR_BITS'($urandom_range(0, `N));
      for (int i = 0; i < `N; i++)
        slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7),
             $urandom_range(0, 63), $urandom_range(0, 63));
      store_commit_ready = $urandom_range(0, 3) != 0;
      store_buffer_empty = $urandom_range(0, 2) == 0;
      if (reset) halted_run = 0;
      else if (m_state == 2) halted_run++;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- In-order commit stage; consumer of the ROB head window.
- Each cycle it inspects up to `N oldest ROB entries and computes how many retire. It drives that count back to the ROB, frees old physical registers, updates the architectural map, and commits at most one store per cycle to the store buffer.
- Owns the halt/drain sequence, a retired-instruction counter and a no-progress watchdog.

Parameters:
- WATCHDOG_CYCLES, 1024, consecutive no-retire cycles with a non-empty window before deadlock asserts.
- CNT_BITS, 64, width of retired_count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rob_outputs  in  ROB_EXIT_PACKET[`N]  oldest-first head window. Fields used: complete, halt, is_store, dest_arch[4:0], t_new, t_old, pc.
- rob_outputs_valid  in  `NUM_SCALAR_BITS  count of valid window entries (0..`N)
- num_retiring  out  `NUM_SCALAR_BITS  entries retired this cycle, to ROB
- store_commit_ready  in  1  store buffer accepts a commit this cycle
- store_commit_valid  out  1  a store retires this cycle
- store_buffer_empty  in  1  no committed stores pending
- free_valid  out  `N  one bit per slot; t_old of that slot is freed
- free_preg  out  `N x `PHYS_REG_BITS  freed physical registers (t_old)
- arch_map_we  out  `N  architectural map write enable per slot
- arch_map_idx  out  `N x 5  architectural register index
- arch_map_preg  out  `N x `PHYS_REG_BITS  new mapping (t_new)
- halted  out  1  registered; processor fully halted
- retired_count  out  CNT_BITS  registered total of retired instructions
- deadlock  out  1  registered, sticky watchdog flag

Behaviour:
- Reset:
  - state=RUN; retired_count=0; halted=0; deadlock=0; watchdog counter=0.
  - All combinational outputs are 0 while reset is high.
- States: RUN, DRAIN, HALTED.
- Retire selection (combinational, zero latency, RUN only). Scan slots i = 0..rob_outputs_valid-1 in order. Slot i retires iff:
  - all of slots 0..i-1 retired;
  - entry i is complete;
  - if is_store: no earlier slot this cycle was a store, and store_commit_ready=1;
  - no earlier slot this cycle had halt=1.
- The scan stops at the first slot that fails. A halt entry itself retires.
- num_retiring = number of retiring slots. It is always <= rob_outputs_valid; the ROB frees exactly that many next edge.
- In DRAIN/HALTED, num_retiring=0 and all free/map/store outputs are 0.
- store_commit_valid=1 iff a retiring slot is a store. store_commit_ready is sampled combinationally; no buffering.
- Per retiring slot i:
  - free_valid[i]=1 and free_preg[i]=t_old, except when dest_arch==0 (no free).
  - arch_map_we[i]=1 iff dest_arch!=0, and no younger retiring slot in the same cycle has the same dest_arch (youngest wins).
  - t_old of a suppressed older write is still freed.
- Non-retiring slots drive 0 on all per-slot outputs.
- Transitions:
  - RUN -> DRAIN at the edge where a halt entry retires.
  - DRAIN -> HALTED at the first edge with store_buffer_empty=1 in DRAIN. halted goes high that edge and holds until reset.
  - If the halt retires with store_buffer_empty already 1 and no store retires the same cycle, the FSM still spends one cycle in DRAIN. halted rises 2 edges after the halt retires.
  - HALTED is left only via reset.
- retired_count <= retired_count + num_retiring every edge; wraps modulo 2^CNT_BITS.
- Watchdog counter, evaluated in RUN:
  - Increments when rob_outputs_valid>0 and num_retiring==0.
  - Clears when num_retiring>0 or rob_outputs_valid==0.
  - Saturates at WATCHDOG_CYCLES.
  - deadlock sets at the edge where the counter reaches WATCHDOG_CYCLES and stays set until reset.
  - The counter is frozen in DRAIN/HALTED.
- Reset mid-DRAIN or mid-HALTED returns to RUN with all counters cleared. In-flight store commits are not replayed.

Test Plan:
- N=3, valid=3, all complete, dest x1/x2/x3, no store: num_retiring=3, free_valid=3'b111, arch_map_we=3'b111. retired_count=3 after the edge.
- valid=3, complete=1/0/1: num_retiring=1, free_valid=3'b001. watchdog=0.
- Slots 0 and 1 both stores, complete, ready=1: num_retiring=1, store_commit_valid=1. Same with ready=0: num_retiring=0, store_commit_valid=0.
- Slots 0 and 2 both write x5 (t_old 10/12, t_new 20/22), all complete: arch_map_we=3'b110 when slot 1 writes another reg, so only slot 2 maps x5->22. free_preg includes 10 and 12.
- Halt in slot 1, slot 2 complete: num_retiring=2; next cycle state=DRAIN, num_retiring=0. Hold store_buffer_empty=0 for 3 cycles, then 1: halted rises at that edge and stays high.
- WATCHDOG_CYCLES=8, valid=1, entry never completes: deadlock=0 through edge 7, 1 at edge 8, still 1 after the entry completes. Clears only on reset.
